fifo_uart_tx: RTL

Drains bytes from a FIFO read port and serialises them onto a UART transmit line, 8N1, LSB first. It is the outbound counterpart of the camera receive path: that path writes UART bytes into a FIFO, and this block reads a FIFO and sends the bytes out over `tx`. It contains its own baud divider and transmit state machine, and needs no external UART core.

---
 rtl/fifo_uart_tx.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_uart_tx
//  Brief    : Drains bytes from a FIFO read port and transmits them as
//             8N1 UART frames, LSB first. The baud divider and the transmit
//             state machine are self-contained.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_uart_tx #(
  parameter int BAUD_DIV = 434,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             fifo_empty,
  output logic             fifo_rd,
  input  logic [7:0]       fifo_data,
  output logic             tx,
  output logic             busy,
  output logic             tx_done,
  output logic [CNT_W-1:0] tx_count
);

  // Baud counter is sized to hold 0 .. BAUD_DIV-1 (BAUD_DIV >= 2).
  localparam int                  c_BAUD_W    = $clog2(BAUD_DIV);
  localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(BAUD_DIV - 1);
  localparam logic [2:0]          c_BIT_LAST  = 3'd7;

  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_READ  = 3'd1;
  localparam logic [2:0] c_ST_LOAD  = 3'd2;
  localparam logic [2:0] c_ST_START = 3'd3;
  localparam logic [2:0] c_ST_DATA  = 3'd4;
  localparam logic [2:0] c_ST_STOP  = 3'd5;

  logic [2:0]          r_state;
  logic [2:0]          w_state_next;
  logic [c_BAUD_W-1:0] r_baud_cnt;
  logic [2:0]          r_bit_idx;
  logic [7:0]          r_shift;
  logic [7:0]          w_shift_next;
  logic                r_tx;
  logic                w_tx_next;
  logic [CNT_W-1:0]    r_tx_count;
  logic                w_bit_end;
  logic                w_in_frame;
  logic                w_can_start;

  // A serial bit period ends when the baud counter reaches its last value.
  assign w_bit_end   = (r_baud_cnt == c_BAUD_LAST);
  assign w_in_frame  = (r_state == c_ST_START) || (r_state == c_ST_DATA) ||
                       (r_state == c_ST_STOP);
  assign w_can_start = enable && !fifo_empty;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: enable and fifo_empty only matter in IDLE and at STOP exit.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_ST_IDLE:  if (w_can_start) w_state_next = c_ST_READ;
      c_ST_READ:  w_state_next = c_ST_LOAD;
      c_ST_LOAD:  w_state_next = c_ST_START;
      c_ST_START: if (w_bit_end) w_state_next = c_ST_DATA;
      c_ST_DATA:  if (w_bit_end && (r_bit_idx == c_BIT_LAST)) w_state_next = c_ST_STOP;
      c_ST_STOP: begin
        if (w_bit_end) begin
          w_state_next = w_can_start ? c_ST_READ : c_ST_IDLE;
        end
      end
      default:    w_state_next = c_ST_IDLE;
    endcase
  end

  // FSM outputs: read strobe in READ, busy outside IDLE, done on last stop cycle.
  always_comb begin
    fifo_rd = (r_state == c_ST_READ);
    busy    = (r_state != c_ST_IDLE);
    tx_done = (r_state == c_ST_STOP) && w_bit_end;
  end

  // Next shift contents and next line level, so tx can be registered glitch-free.
  always_comb begin
    w_shift_next = r_shift;
    if (r_state == c_ST_LOAD) begin
      w_shift_next = fifo_data;
    end else if ((r_state == c_ST_DATA) && w_bit_end) begin
      w_shift_next = {1'b0, r_shift[7:1]};
    end
    case (w_state_next)
      c_ST_START: w_tx_next = 1'b0;
      c_ST_DATA:  w_tx_next = w_shift_next[0];
      default:    w_tx_next = 1'b1;
    endcase
  end

  // Baud counter: runs only inside a frame, restarting at every bit boundary.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_baud_cnt <= '0;
    end else if (w_in_frame && !w_bit_end) begin
      r_baud_cnt <= r_baud_cnt + c_BAUD_W'(1);
    end else begin
      r_baud_cnt <= '0;
    end
  end

  // Bit index: advances at each data-bit boundary and rolls back to 0 after bit 7.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bit_idx <= 3'd0;
    end else if (r_state != c_ST_DATA) begin
      r_bit_idx <= 3'd0;
    end else if (w_bit_end) begin
      r_bit_idx <= r_bit_idx + 3'd1;
    end
  end

  // Shift register and serial line; tx returns high asynchronously on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift <= 8'h00;
      r_tx    <= 1'b1;
    end else begin
      r_shift <= w_shift_next;
      r_tx    <= w_tx_next;
    end
  end

  // Completed-byte counter, wrapping naturally at its width.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_count <= '0;
    end else if (tx_done) begin
      r_tx_count <= r_tx_count + CNT_W'(1);
    end
  end

  assign tx       = r_tx;
  assign tx_count = r_tx_count;

endmodule
`default_nettype wire
